encoder_tx_ctrl: RTL and testbench

ENCODER_TX_CTRL -- requirements
Module: encoder_tx_ctrl

---
 rtl/encoder_tx_ctrl.sv | 118 +++++++++++
 tb/tb_encoder_tx_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_tx_ctrl.sv
// encoder_tx_ctrl: round-robin two-requester byte stream arbiter driving an encoder transmit port with gap control
module encoder_tx_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_s0_valid,
  output logic        io_s0_ready,
  input  logic [7:0]  io_s0_data,
  input  logic        io_s0_last,
  input  logic        io_s0_error,
  input  logic        io_s1_valid,
  output logic        io_s1_ready,
  input  logic [7:0]  io_s1_data,
  input  logic        io_s1_last,
  input  logic        io_s1_error,
  input  logic        io_loc_rcvr_status,
  input  logic        io_tx_mode,
  input  logic [7:0]  io_ipg_cycles,
  output logic        io_tx_enable,
  output logic        io_tx_error,
  output logic [7:0]  io_tx_data,
  output logic [31:0] io_n,
  output logic [31:0] io_n0,
  output logic [1:0]  io_grant,
  output logic        io_busy,
  output logic        io_underrun,
  output logic [15:0] io_frames_sent
);
  typedef enum logic [1:0] {IDLE, XMIT, DRAIN, IPG} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d;
  logic [7:0] gap_q, gap_d, data_d, gap_load;
  logic en_d, err_d, und_d;
  logic [15:0] frames_d;
  logic sel_valid, sel_last, sel_err, pick, moving;
  logic [7:0] sel_data;
  assign moving      = (state_q == XMIT) || (state_q == DRAIN);
  assign io_s0_ready = moving && !owner_q;
  assign io_s1_ready = moving && owner_q;
  assign sel_valid   = owner_q ? io_s1_valid : io_s0_valid;
  assign sel_last    = owner_q ? io_s1_last  : io_s0_last;
  assign sel_err     = owner_q ? io_s1_error : io_s0_error;
  assign sel_data    = owner_q ? io_s1_data  : io_s0_data;
  // last_q records the previous winner; on a tie the other requester wins
  assign pick        = (io_s0_valid && io_s1_valid) ? ~last_q : io_s1_valid;
  assign gap_load    = (io_ipg_cycles == 8'd0) ? 8'd1 : io_ipg_cycles;
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    gap_d    = gap_q;
    en_d     = 1'b0;
    err_d    = 1'b0;
    data_d   = 8'h00;
    und_d    = 1'b0;
    frames_d = io_frames_sent;
    case (state_q)
      IDLE: if (io_loc_rcvr_status && io_tx_mode && (io_s0_valid || io_s1_valid)) begin
        state_d = XMIT;
        owner_d = pick;
        last_d  = pick;
      end
      XMIT: if (sel_valid) begin
        en_d   = 1'b1;
        err_d  = sel_err;
        data_d = sel_data;
        if (sel_last) begin
          state_d  = IPG;
          gap_d    = gap_load;
          frames_d = io_frames_sent + 16'd1;
        end
      end else begin
        en_d    = 1'b1;
        err_d   = 1'b1;
        und_d   = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: if (sel_valid && sel_last) begin
        state_d = IPG;
        gap_d   = gap_load;
      end
      default: begin
        gap_d   = gap_q - 8'd1;
        state_d = (gap_q == 8'd1) ? IDLE : IPG;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      last_q         <= 1'b1;
      gap_q          <= 8'd0;
      io_tx_enable   <= 1'b0;
      io_tx_error    <= 1'b0;
      io_tx_data     <= 8'h00;
      io_n           <= 32'd0;
      io_n0          <= 32'd0;
      io_grant       <= 2'b00;
      io_busy        <= 1'b0;
      io_underrun    <= 1'b0;
      io_frames_sent <= 16'd0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      gap_q          <= gap_d;
      io_tx_enable   <= en_d;
      io_tx_error    <= err_d;
      io_tx_data     <= data_d;
      io_n           <= io_n + 32'd1;
      io_n0          <= (en_d && !io_tx_enable) ? io_n + 32'd1 : io_n0;
      io_grant       <= (state_d == IDLE) ? 2'b00 : {owner_d, ~owner_d};
      io_busy        <= state_d != IDLE;
      io_underrun    <= und_d;
      io_frames_sent <= frames_d;
    end
  end
endmodule

// File: tb/tb_encoder_tx_ctrl.sv
// tb_encoder_tx_ctrl: randomized and directed checks of encoder_tx_ctrl against a transaction-level reference model
module tb_encoder_tx_ctrl;
  logic clock = 1'b0, reset = 1'b1;
  logic s0_valid, s0_ready, s0_last, s0_error, s1_valid, s1_ready, s1_last, s1_error;
  logic [7:0] s0_data, s1_data, ipg;
  logic status = 1'b1, mode = 1'b1;
  logic tx_enable, tx_error, busy, underrun;
  logic [7:0] tx_data;
  logic [31:0] n, n0;
  logic [1:0] grant;
  logic [15:0] frames;
  always #5 clock = ~clock;

  encoder_tx_ctrl dut (
    .clock(clock), .reset(reset),
    .io_s0_valid(s0_valid), .io_s0_ready(s0_ready), .io_s0_data(s0_data), .io_s0_last(s0_last), .io_s0_error(s0_error),
    .io_s1_valid(s1_valid), .io_s1_ready(s1_ready), .io_s1_data(s1_data), .io_s1_last(s1_last), .io_s1_error(s1_error),
    .io_loc_rcvr_status(status), .io_tx_mode(mode), .io_ipg_cycles(ipg),
    .io_tx_enable(tx_enable), .io_tx_error(tx_error), .io_tx_data(tx_data), .io_n(n), .io_n0(n0),
    .io_grant(grant), .io_busy(busy), .io_underrun(underrun), .io_frames_sent(frames)
  );

  int checks = 0, failures = 0;
  int vprob = 100;
  logic [9:0] q0[$], q1[$];

  localparam int P_IDLE = 0, P_SEND = 1, P_DROP = 2, P_GAP = 3;
  int ph = P_IDLE, gap_left = 0, owner = 0, prev_winner = 1;
  logic m_en = 0, m_err = 0, m_busy = 0, m_und = 0;
  logic [7:0] m_data = 0;
  logic [31:0] m_n = 0, m_n0 = 0;
  logic [1:0] m_grant = 0;
  logic [15:0] m_frames = 0;

  logic [7:0] cap[$];
  int lows[$], grants[$];
  int und_cnt = 0, err_cnt = 0, low_run = 0;
  bit seen_high = 0;
  logic [1:0] prev_grant = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int who, input int len, input int err_at);
    for (int i = 0; i < len; i++) begin
      logic [9:0] e;
      e = {(i == len - 1) ? 1'b1 : 1'b0, (i == err_at) ? 1'b1 : 1'b0, 8'($urandom)};
      if (who == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic clear_track();
    cap.delete(); lows.delete(); grants.delete();
    und_cnt = 0; err_cnt = 0; low_run = 0; seen_high = 0;
  endtask

  task automatic cycle();
    logic [9:0] h0, h1, h;
    bit r0, r1, v, prev_en;
    h0 = (q0.size() != 0) ? q0[0] : 10'h0;
    h1 = (q1.size() != 0) ? q1[0] : 10'h0;
    s0_valid = (q0.size() != 0) && ($urandom_range(99) < vprob);
    s1_valid = (q1.size() != 0) && ($urandom_range(99) < vprob);
    {s0_last, s0_error, s0_data} = h0;
    {s1_last, s1_error, s1_data} = h1;
    r0 = (ph == P_SEND || ph == P_DROP) && owner == 0;
    r1 = (ph == P_SEND || ph == P_DROP) && owner == 1;
    #3;
    chk("ready0", 32'(s0_ready), 32'(r0));
    chk("ready1", 32'(s1_ready), 32'(r1));
    @(posedge clock);
    if (reset) begin
      ph = P_IDLE; owner = 0; prev_winner = 1; gap_left = 0;
      m_en = 0; m_err = 0; m_data = 0; m_n = 0; m_n0 = 0;
      m_grant = 0; m_busy = 0; m_und = 0; m_frames = 0;
    end else begin
      prev_en = m_en;
      m_n = m_n + 1;
      m_en = 0; m_err = 0; m_data = 0; m_und = 0;
      v = owner ? s1_valid : s0_valid;
      h = owner ? h1 : h0;
      if (ph == P_IDLE) begin
        if (status && mode && (s0_valid || s1_valid)) begin
          owner = (s0_valid && s1_valid) ? 1 - prev_winner : (s1_valid ? 1 : 0);
          prev_winner = owner;
          ph = P_SEND;
        end
      end else if (ph == P_SEND) begin
        m_en = 1;
        if (v) begin
          m_err = h[8]; m_data = h[7:0];
          if (h[9]) begin
            m_frames = m_frames + 1;
            gap_left = (ipg == 0) ? 1 : int'(ipg);
            ph = P_GAP;
          end
        end else begin
          m_err = 1; m_und = 1; ph = P_DROP;
        end
      end else if (ph == P_DROP) begin
        if (v && h[9]) begin
          gap_left = (ipg == 0) ? 1 : int'(ipg);
          ph = P_GAP;
        end
      end else begin
        gap_left--;
        if (gap_left == 0) ph = P_IDLE;
      end
      m_grant = (ph == P_IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
      m_busy = ph != P_IDLE;
      if (m_en && !prev_en) m_n0 = m_n;
      if (s0_valid && r0) void'(q0.pop_front());
      if (s1_valid && r1) void'(q1.pop_front());
    end
    #1;
    chk("tx_enable", 32'(tx_enable), 32'(m_en));
    chk("tx_error", 32'(tx_error), 32'(m_err));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("n", n, m_n);
    chk("n0", n0, m_n0);
    chk("grant", 32'(grant), 32'(m_grant));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("underrun", 32'(underrun), 32'(m_und));
    chk("frames_sent", 32'(frames), 32'(m_frames));
    if (tx_enable === 1'b1) begin
      cap.push_back(tx_data);
      if (seen_high && low_run > 0) lows.push_back(low_run);
      low_run = 0; seen_high = 1;
    end else low_run++;
    if (tx_error === 1'b1) err_cnt++;
    if (underrun === 1'b1) und_cnt++;
    if (prev_grant == 2'b00 && grant != 2'b00) grants.push_back(int'(grant));
    prev_grant = grant;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic do_reset(input int k);
    reset = 1; q0.delete(); q1.delete();
    run(k);
    reset = 0;
    clear_track();
  endtask

  initial begin
    ipg = 8'd4; vprob = 100;
    do_reset(3);
    chk("rst_n", n, 32'd0);
    chk("rst_frames", 32'(frames), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    q0.push_back(10'h0F0); q0.push_back(10'h011); q0.push_back(10'h022); q0.push_back(10'h233);
    run(12);
    chk("f1_len", cap.size(), 32'd4);
    if (cap.size() == 4) begin
      chk("f1_b0", 32'(cap[0]), 32'hF0);
      chk("f1_b1", 32'(cap[1]), 32'h11);
      chk("f1_b2", 32'(cap[2]), 32'h22);
      chk("f1_b3", 32'(cap[3]), 32'h33);
    end
    chk("f1_frames", 32'(frames), 32'd1);
    chk("f1_err", err_cnt, 32'd0);
    chk("f1_n0", n0, 32'd2);

    do_reset(1);
    ipg = 8'd2;
    for (int i = 0; i < 4; i++) begin push_frame(0, 2, -1); push_frame(1, 2, -1); end
    run(50);
    chk("rr_cnt", grants.size(), 32'd8);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("rr_grant", grants[i], (i % 2 == 0) ? 32'd1 : 32'd2);
    chk("rr_gaps", lows.size(), 32'd7);
    for (int i = 0; i < lows.size(); i++) chk("rr_gap_len", lows[i], 32'd3);

    do_reset(1);
    status = 0;
    push_frame(0, 2, -1);
    run(5);
    chk("nostat_grant", 32'(grant), 32'd0);
    chk("nostat_en", 32'(tx_enable), 32'd0);
    chk("nostat_ready", 32'(s0_ready), 32'd0);
    status = 1; mode = 0;
    run(3);
    chk("nomode_busy", 32'(busy), 32'd0);
    mode = 1;
    run(1);
    chk("stat_busy", 32'(busy), 32'd1);
    chk("stat_grant", 32'(grant), 32'd1);
    run(8);

    do_reset(1);
    ipg = 8'd3;
    q1.push_back(10'h0A1); q1.push_back(10'h0A2);
    run(6);
    q1.push_back(10'h0A3); q1.push_back(10'h0A4); q1.push_back(10'h2A5);
    run(12);
    chk("ur_pulses", und_cnt, 32'd1);
    chk("ur_frames", 32'(frames), 32'd0);
    chk("ur_len", cap.size(), 32'd3);
    if (cap.size() == 3) chk("ur_data", 32'(cap[2]), 32'd0);
    chk("ur_err", err_cnt, 32'd1);

    do_reset(1);
    ipg = 8'd0;
    push_frame(0, 4, 1);
    push_frame(0, 2, -1);
    run(20);
    chk("er_cnt", err_cnt, 32'd1);
    chk("er_frames", 32'(frames), 32'd2);
    chk("er_gap0", lows.size(), 32'd1);
    if (lows.size() == 1) chk("er_gap_len", lows[0], 32'd2);

    do_reset(1);
    ipg = 8'd2;
    push_frame(0, 5, -1);
    run(3);
    reset = 1;
    run(1);
    reset = 0;
    chk("abort_en", 32'(tx_enable), 32'd0);
    chk("abort_n", n, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(s0_ready), 32'd0);
    q0.delete();
    force dut.io_n = 32'hFFFF_FFFE;
    m_n = 32'hFFFF_FFFE;
    #1 release dut.io_n;
    run(2);
    chk("wrap_n", n, 32'd0);
    run(2);

    vprob = 85;
    do_reset(2);
    for (int c = 0; c < 4000; c++) begin
      if (q0.size() < 3) push_frame(0, $urandom_range(1, 6), ($urandom_range(9) == 0) ? $urandom_range(0, 5) : -1);
      if (q1.size() < 3) push_frame(1, $urandom_range(1, 6), ($urandom_range(9) == 0) ? $urandom_range(0, 5) : -1);
      if ($urandom_range(19) == 0) status = $urandom_range(5) != 0;
      if ($urandom_range(19) == 0) mode = $urandom_range(5) != 0;
      if ($urandom_range(29) == 0) ipg = 8'($urandom_range(0, 5));
      reset = $urandom_range(499) == 0;
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
